// File: rtl/loader_pkg.sv
// Shared state encoding and stream framing constants for the instruction loader.
package loader_pkg;

  typedef enum logic [2:0] {
    S_COUNT,
    S_CHECK,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_e;

  localparam int HEADER_BYTES = 4;
  localparam int WORD_BYTES   = 4;

endpackage

// File: rtl/byte_assembler.sv
// Collects four stream bytes into a little-endian 32-bit word; the first byte lands in bits 7:0.
module byte_assembler
  import loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clear_i,
  input  logic        byte_fire_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_complete_o
);

  localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);

  logic [1:0]  count_q;
  logic [31:0] word_q;

  // Shifting in from the top leaves the first byte in the low lane after four bytes.
  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      count_q <= 2'd0;
      word_q  <= 32'd0;
    end else if (byte_fire_i) begin
      count_q <= count_q + 2'd1;
      word_q  <= {byte_i, word_q[31:8]};
    end
  end

  assign word_o          = word_q;
  assign word_complete_o = byte_fire_i && (count_q == LAST_BYTE);

endmodule

// File: rtl/instruction_loader.sv
// Loads a length-prefixed byte stream into instruction memory and releases the core when done.
module instruction_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 256,
  parameter int          COUNT_WIDTH = 32
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output logic        imem_write_enable_o,
  output logic [31:0] imem_address_o,
  output logic [31:0] imem_data_o,
  output logic        core_reset_o,
  output logic        done_o,
  output logic        error_o
);

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] count_q, index_q, header_n;
  logic                   ready_q, we_q, core_reset_q, done_q, error_q;
  logic [31:0]            addr_q, data_q;
  logic [31:0]            asm_word;
  logic                   asm_complete;
  logic                   byte_fire;

  assign byte_fire = byte_valid_i && ready_q;
  assign header_n  = COUNT_WIDTH'(asm_word);

  byte_assembler u_assembler (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .clear_i         (state_q == S_CHECK),
    .byte_fire_i     (byte_fire),
    .byte_i          (byte_data_i),
    .word_o          (asm_word),
    .word_complete_o (asm_complete)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_COUNT: if (asm_complete) state_d = S_CHECK;
      S_CHECK: begin
        if (header_n == '0)                                state_d = S_DONE;
        else if (header_n > COUNT_WIDTH'(DEPTH_WORDS))     state_d = S_ERROR;
        else                                               state_d = S_DATA;
      end
      S_DATA:  if (asm_complete) state_d = S_WRITE;
      S_WRITE: state_d = (index_q + COUNT_WIDTH'(1) == count_q) ? S_DONE : S_DATA;
      default: state_d = state_q;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_COUNT;
      count_q      <= '0;
      index_q      <= '0;
      ready_q      <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= BASE_ADDR;
      data_q       <= 32'd0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ready_q      <= (state_d == S_COUNT) || (state_d == S_DATA);
      we_q         <= (state_d == S_WRITE);
      core_reset_q <= (state_d != S_DONE);
      done_q       <= (state_d == S_DONE);
      error_q      <= (state_d == S_ERROR);
      if (state_q == S_CHECK) begin
        count_q <= header_n;
        index_q <= '0;
      end
      if (state_q == S_WRITE) begin
        index_q <= index_q + COUNT_WIDTH'(1);
        data_q  <= asm_word;
      end
      if (state_d == S_WRITE) begin
        addr_q <= BASE_ADDR + (32'(index_q) << 2);
      end
    end
  end

  // The assembler is frozen during S_WRITE, so its word is presented directly on the strobe
  // cycle and a registered copy holds it afterwards.
  assign imem_data_o         = we_q ? asm_word : data_q;
  assign imem_address_o      = addr_q;
  assign imem_write_enable_o = we_q;
  assign byte_ready_o        = ready_q;
  assign core_reset_o        = core_reset_q;
  assign done_o              = done_q;
  assign error_o             = error_q;

endmodule
